// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes,
// data-memory wait freeze with timeout, and stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_access,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             pipeline_stall,
  output logic             pipe_freeze,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic [WCNT_W-1:0]   wait_inc;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
  logic                load_use;
  logic                flush_ev;

  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign wait_inc = wait_q + WCNT_W'(1);

  // State, wait counter and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!PCWrite && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Next-state and combinational pipeline control decisions
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    PCWrite        = 1'b1;
    IF_IDWrite     = 1'b1;
    pipeline_stall = 1'b0;
    pipe_freeze    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    dmem_req       = 1'b0;
    mem_err        = 1'b0;
    flush_ev       = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        dmem_req = mem_access;
        if ((state_q == RUN) ? (mem_access && !dmem_ready) : !dmem_ready) begin
          // Access outstanding: freeze everything
          PCWrite     = 1'b0;
          IF_IDWrite  = 1'b0;
          pipe_freeze = 1'b1;
          if (state_q == RUN) begin
            state_d = MEM_WAIT;
            wait_d  = WCNT_W'(1);
          end else begin
            wait_d = wait_inc;
            if (wait_inc == WCNT_W'(TIMEOUT)) state_d = ERROR;
          end
        end else begin
          // Pipeline advances; a branch alongside a memory op is ignored
          state_d = RUN;
          wait_d  = '0;
          if (branch_taken && !mem_access) begin
            pipeline_stall = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            ex_mem_flush   = 1'b1;
            flush_ev       = 1'b1;
          end else if (load_use) begin
            PCWrite        = 1'b0;
            IF_IDWrite     = 1'b0;
            pipeline_stall = 1'b1;
          end
        end
      end
      ERROR: begin
        PCWrite     = 1'b0;
        IF_IDWrite  = 1'b0;
        pipe_freeze = 1'b1;
        mem_err     = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    // Reset overrides: hold the front end and inject bubbles
    if (!rst_n) begin
      PCWrite        = 1'b0;
      IF_IDWrite     = 1'b0;
      pipeline_stall = 1'b1;
      pipe_freeze    = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      dmem_req       = 1'b0;
      mem_err        = 1'b0;
      flush_ev       = 1'b0;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_MemRead, mem_access, branch_taken, dmem_ready;
  logic        PCWrite, IF_IDWrite, pipeline_stall, pipe_freeze;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, dmem_req, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_PCWrite, s_IF_IDWrite, s_pipeline_stall, s_pipe_freeze;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_dmem_req, s_mem_err;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .mem_access(mem_access),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .pipeline_stall(pipeline_stall),
    .pipe_freeze(pipe_freeze), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .mem_access(mem_access),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .PCWrite(s_PCWrite), .IF_IDWrite(s_IF_IDWrite), .pipeline_stall(s_pipeline_stall),
    .pipe_freeze(s_pipe_freeze), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .dmem_req(s_dmem_req), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs sample here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_MemRead = 1'b0; mem_access = 1'b0; branch_taken = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  // Packs {PCWrite, IF_IDWrite, pipeline_stall, pipe_freeze}
  function automatic logic [3:0] ctl();
    return {PCWrite, IF_IDWrite, pipeline_stall, pipe_freeze};
  endfunction

  function automatic logic [2:0] fl();
    return {if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    #7;
    check("rst_ctl", 32'(ctl()), 32'b0010);
    check("rst_flush", 32'(fl()), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;

    // Normal first cycle after reset
    #1;
    check("post_rst_ctl", 32'(ctl()), 32'b1100);
    tick();

    // Load-use hazard: one bubble
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    #1;
    check("lu_ctl", 32'(ctl()), 32'b0010);
    tick();
    idle();
    #1;
    check("lu_stall_cnt", stall_cnt, 32'd1);
    check("lu_after_ctl", 32'(ctl()), 32'b1100);

    // Load to x0 never stalls
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    check("lu_x0_ctl", 32'(ctl()), 32'b1100);
    tick();
    idle();

    // Taken branch overrides load-use
    do_reset();
    branch_taken = 1'b1; ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    #1;
    check("br_ctl", 32'(ctl()), 32'b1110);
    check("br_flush", 32'(fl()), 32'b111);
    tick();
    idle();
    #1;
    check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_stall_cnt", stall_cnt, 32'd0);

    // Branch with memory access: memory wins
    mem_access = 1'b1; branch_taken = 1'b1; dmem_ready = 1'b1;
    #1;
    check("br_mem_flush", 32'(fl()), 32'd0);
    tick();
    idle();
    #1;
    check("br_mem_flush_cnt", flush_cnt, 32'd1);

    // Memory wait: 3 frozen cycles, then release
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_ctl%0d", i), 32'(ctl()), 32'b0001);
      check($sformatf("mw_req%0d", i), 32'(dmem_req), 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    check("mw_release_ctl", 32'(ctl()), 32'b1100);
    tick();
    idle();
    #1;
    check("mw_stall_cnt", stall_cnt, 32'd3);

    // Zero-wait access
    mem_access = 1'b1; dmem_ready = 1'b1;
    #1;
    check("zw_ctl", 32'(ctl()), 32'b1100);
    tick();
    idle();
    #1;
    check("zw_stall_cnt", stall_cnt, 32'd3);

    // Timeout: 16 frozen cycles then ERROR
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("to_ctl%0d", i), 32'(ctl()), 32'b0001);
      check($sformatf("to_err%0d", i), 32'(mem_err), (i >= 16) ? 32'd1 : 32'd0);
      check($sformatf("to_req%0d", i), 32'(dmem_req), (i >= 16) ? 32'd0 : 32'd1);
      tick();
    end
    #1;
    check("to_stall_cnt", stall_cnt, 32'd20);
    check("sat_stall_cnt", 32'(s_stall_cnt), 32'd15);
    dmem_ready = 1'b1; mem_access = 1'b0;
    #1;
    check("to_sticky_err", 32'(mem_err), 32'd1);
    check("to_sticky_pc", 32'(PCWrite), 32'd0);
    tick();
    #1;
    check("to_sticky_err2", 32'(mem_err), 32'd1);

    // Reset asserted mid-MEM_WAIT
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    #1;
    check("rmw_pre_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_req", 32'(dmem_req), 32'd0);
    check("rmw_freeze", 32'(pipe_freeze), 32'd0);
    check("rmw_stall_cnt", stall_cnt, 32'd0);
    check("rmw_flush_cnt", flush_cnt, 32'd0);
    rst_n = 1'b1;
    idle();
    #1;
    check("rmw_after_ctl", 32'(ctl()), 32'b1100);
    check("rmw_after_err", 32'(mem_err), 32'd0);
    tick();

    // Load-use on the ready cycle of a wait
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    dmem_ready = 1'b1; ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    #1;
    check("mw_lu_ctl", 32'(ctl()), 32'b0010);
    tick();
    idle();
    #1;
    check("mw_lu_stall_cnt", stall_cnt, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
